alu_logic_unit: RTL and testbench

Bitwise logic sub-unit of the ALU datapath, operating on two OPD_LENGTH-bit operands.
- Selected by the 4-bit ALU op code.
- Result and status flags are registered: one-cycle latency, valid-qualified output.
- Sits beside the arithmetic and shift sub-units; the ALU output mux picks its result.

---
 rtl/alu_logic_unit.sv | 86 ++++++++
 tb/tb_alu_logic_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_unit.sv
// alu_logic_unit: bitwise logic sub-unit of the ALU datapath.
// Computes NOT/AND/OR/XOR on two OPD_LENGTH-bit operands, selected by a 4-bit
// op code. The result, zero/parity flags and an illegal-op flag are registered
// with one cycle of latency and qualified by out_valid.
// Optional build macro LOGIC_UNIT_EXT_OPS_EN enables the NAND/NOR/XNOR codes.
// Without the macro, those codes are treated as illegal.
module alu_logic_unit #(
  parameter int unsigned OPD_LENGTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [OPD_LENGTH-1:0] opd1,
  input  logic [OPD_LENGTH-1:0] opd2,
  input  logic [3:0]            alu_op_select,
  output logic                  out_valid,
  output logic [OPD_LENGTH-1:0] logic_result,
  output logic                  zero_flag,
  output logic                  parity_flag,
  output logic                  illegal_op
);

  typedef enum logic [3:0] {
    OP_NOT1 = 4'b0000,
    OP_NOT2 = 4'b0001,
    OP_NAND = 4'b0010,
    OP_NOR  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_XNOR = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111
  } logic_op_e;

  logic [OPD_LENGTH-1:0] next_result;
  logic                  next_illegal;
  logic                  next_zero;
  logic                  next_parity;

  // Decode the op code into a result; unsupported codes produce zero and flag illegal
  always_comb begin
    next_result  = '0;
    next_illegal = 1'b0;
    case (alu_op_select)
      OP_NOT1: next_result = ~opd1;
      OP_NOT2: next_result = ~opd2;
      OP_AND:  next_result = opd1 & opd2;
      OP_OR:   next_result = opd1 | opd2;
      OP_XOR:  next_result = opd1 ^ opd2;
`ifdef LOGIC_UNIT_EXT_OPS_EN
      OP_NAND: next_result = ~(opd1 & opd2);
      OP_NOR:  next_result = ~(opd1 | opd2);
      OP_XNOR: next_result = ~(opd1 ^ opd2);
`endif
      default: begin
        next_result  = '0;
        next_illegal = 1'b1;
      end
    endcase
  end

  // Status flags derive from the result, so illegal codes yield zero=1, parity=0
  always_comb begin
    next_zero   = (next_result == '0);
    next_parity = ^next_result;
  end

  // Output register: capture on valid input, otherwise hold data and drop valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      logic_result <= '0;
      zero_flag    <= 1'b0;
      parity_flag  <= 1'b0;
      illegal_op   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        logic_result <= next_result;
        zero_flag    <= next_zero;
        parity_flag  <= next_parity;
        illegal_op   <= next_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_logic_unit.sv
// tb_alu_logic_unit: scoreboard bench for alu_logic_unit (OPD_LENGTH = 8).
// The driver pushes the expected response once the DUT has captured an input.
// A separate monitor pops each entry on the following falling edge and compares it.
module tb_alu_logic_unit;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] opd1 = '0;
  logic [W-1:0] opd2 = '0;
  logic [3:0]   alu_op_select = '0;
  logic         out_valid;
  logic [W-1:0] logic_result;
  logic         zero_flag;
  logic         parity_flag;
  logic         illegal_op;

  alu_logic_unit #(.OPD_LENGTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .opd1(opd1),
    .opd2(opd2),
    .alu_op_select(alu_op_select),
    .out_valid(out_valid),
    .logic_result(logic_result),
    .zero_flag(zero_flag),
    .parity_flag(parity_flag),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] r;
    logic         z;
    logic         p;
    logic         i;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state: the last accepted result and flags
  logic [W-1:0] m_r = '0;
  logic         m_z = 1'b0;
  logic         m_p = 1'b0;
  logic         m_i = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"},  {31'd0, out_valid},   32'd0);
    chk({name, "_result"}, {24'd0, logic_result}, 32'd0);
    chk({name, "_zero"},   {31'd0, zero_flag},   32'd0);
    chk({name, "_parity"}, {31'd0, parity_flag}, 32'd0);
    chk({name, "_illegal"},{31'd0, illegal_op},  32'd0);
  endtask

  // Compute the result from the operation rules; the flags follow from counting ones
  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic ill);
    int unsigned n;
    ill = 1'b0;
    res = '0;
    n = op;
    if      (n == 0) res = ~a;
    else if (n == 1) res = ~b;
    else if (n == 7) res = a & b;
    else if (n == 6) res = a | b;
    else if (n == 4) res = a ^ b;
`ifdef LOGIC_UNIT_EXT_OPS_EN
    else if (n == 2) res = ~(a & b);
    else if (n == 3) res = ~(a | b);
    else if (n == 5) res = ~(a ^ b);
`endif
    else ill = 1'b1;
  endfunction

  // Drive one cycle of stimulus; after the capturing edge, push the expected response
  task automatic issue(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    exp_t e;
    logic [W-1:0] res;
    logic ill;
    int ones;
    @(negedge clk);
    in_valid = v;
    opd1 = a;
    opd2 = b;
    alu_op_select = op;
    @(posedge clk);
    if (v) begin
      model(op, a, b, res, ill);
      ones = 0;
      for (int unsigned k = 0; k < W; k++) ones += int'(res[k]);
      m_r = res;
      m_i = ill;
      m_z = (ones == 0);
      m_p = (ones % 2) == 1;
    end
    e.v = v; e.r = m_r; e.z = m_z; e.p = m_p; e.i = m_i;
    q.push_back(e);
  endtask

  // Monitor: compare each presented output against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_valid",   {31'd0, out_valid},    {31'd0, e.v});
        chk("result",      {24'd0, logic_result}, {24'd0, e.r});
        chk("zero_flag",   {31'd0, zero_flag},    {31'd0, e.z});
        chk("parity_flag", {31'd0, parity_flag},  {31'd0, e.p});
        chk("illegal_op",  {31'd0, illegal_op},   {31'd0, e.i});
      end else begin
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  initial begin
    logic [3:0] ops[5];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0111; ops[3] = 4'b0110; ops[4] = 4'b0100;

    // Power-on reset
    #1 chk_zero("por");
    repeat (2) @(negedge clk);
    chk_zero("por_held");
    rst = 1'b0;

    // One accepted op, then an asynchronous reset between edges with a new op in flight
    issue(1'b1, 8'hCC, 8'hFF, 4'b0111);
    @(negedge clk);
    in_valid = 1'b1; opd1 = 8'hCC; opd2 = 8'hFF; alu_op_select = 4'b0000;
    #2 rst = 1'b1;
    q.delete();
    #1 chk_zero("async_rst");
    repeat (2) begin
      @(negedge clk);
      chk_zero("rst_held");
    end
    in_valid = 1'b0;
    rst = 1'b0;
    m_r = '0; m_z = 1'b0; m_p = 1'b0; m_i = 1'b0;
    issue(1'b1, 8'h00, 8'h00, 4'b0000);

    // Back-to-back base ops on two operand pairs
    foreach (ops[k]) issue(1'b1, 8'hCC, 8'hFF, ops[k]);
    foreach (ops[k]) issue(1'b1, 8'h0E, 8'hA0, ops[k]);

    // Illegal op followed by a legal op
    issue(1'b1, 8'hCC, 8'hFF, 4'b1111);
    issue(1'b1, 8'hCC, 8'hFF, 4'b0111);

    // Valid gaps: results must hold
    issue(1'b1, 8'h5A, 8'h0F, 4'b0100);
    issue(1'b0, 8'h12, 8'h34, 4'b0000);
    issue(1'b0, 8'h56, 8'h78, 4'b0001);
    issue(1'b1, 8'h00, 8'h00, 4'b0000);

    // Extended-op codes (legal or illegal depending on the build)
    issue(1'b1, 8'hCC, 8'hFF, 4'b0010);
    issue(1'b1, 8'hCC, 8'hFF, 4'b0011);
    issue(1'b1, 8'hCC, 8'hFF, 4'b0101);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      issue($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), 4'($urandom_range(0, 15)));
    end

    issue(1'b0, '0, '0, '0);
    issue(1'b0, '0, '0, '0);
    for (int n = 0; n < 20 && q.size() > 0; n++) @(negedge clk);
    if (q.size() != 0) chk("drain", q.size(), 32'd0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
